// File: rtl/rr_decode_arbiter.sv
// Purpose : 8-way round-robin arbiter sharing one 3-to-8 decoded resource.
// Latency : grant registered 1 cycle after arbitration; 1 dead cycle between grants.
// Backpr. : no backpressure; a grant is held until req drop, release_i or MAX_HOLD.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   req           request vector, bit i = requester i
//   release_i     1-cycle pulse from the current owner ending its grant
//   grant_valid   grant active this cycle
//   grant_idx     winning index (decoder select), 0 when idle
//   grant_onehot  1 << grant_idx when valid, else 0
//   timeout_o     1-cycle pulse in the dead cycle when MAX_HOLD alone ended the grant
module rr_decode_arbiter #(
   parameter int NREQ     = 8,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 15,
   parameter int HOLD_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic              release_i,
   output logic              grant_valid,
   output logic [IDX_W-1:0]  grant_idx,
   output logic [NREQ-1:0]   grant_onehot,
   output logic              timeout_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_GAP
   } state_t;

   localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
   localparam logic [NREQ-1:0]   ONE_HOT0   = {{(NREQ-1){1'b0}}, 1'b1};

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   last_ptr, last_nxt;
   logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
   logic               valid_nxt;
   logic [IDX_W-1:0]   idx_nxt;
   logic [NREQ-1:0]    onehot_nxt;
   logic               timeout_nxt;

   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   cand;
   logic               win_found;
   logic               end_a, end_b, end_c;

   // Round-robin search starting one past the last owner. The index adder
   // wraps modulo 8 by width, so k=8 lands back on last_ptr itself, letting a
   // sole requester re-win.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = last_ptr + IDX_W'(k);
         if (!win_found && req[cand]) begin
            win_idx   = cand;
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      valid_nxt   = 1'b0;
      idx_nxt     = '0;
      onehot_nxt  = '0;
      timeout_nxt = 1'b0;
      last_nxt    = last_ptr;
      hold_nxt    = hold_cnt;
      end_a       = ~req[grant_idx];
      end_b       = release_i;
      end_c       = (MAX_HOLD != 0) && (hold_cnt == MAX_HOLD_C);

      case (state)
         // IDLE and the dead cycle arbitrate identically on the req seen now.
         S_IDLE, S_GAP: begin
            hold_nxt = '0;
            if (win_found) begin
               state_nxt  = S_GRANT;
               valid_nxt  = 1'b1;
               idx_nxt    = win_idx;
               onehot_nxt = ONE_HOT0 << win_idx;
               hold_nxt   = HOLD_W'(1);
            end else begin
               state_nxt  = S_IDLE;
            end
         end
         S_GRANT: begin
            if (end_a || end_b || end_c) begin
               state_nxt   = S_GAP;
               // Voluntary ends (req drop / release) mask the timeout flag.
               timeout_nxt = end_c & ~end_a & ~end_b;
               last_nxt    = grant_idx;
               hold_nxt    = '0;
            end else begin
               valid_nxt  = 1'b1;
               idx_nxt    = grant_idx;
               onehot_nxt = grant_onehot;
               // Saturate instead of wrapping (only reachable with MAX_HOLD=0).
               if (hold_cnt != '1) begin
                  hold_nxt = hold_cnt + HOLD_W'(1);
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         last_ptr     <= IDX_W'(NREQ - 1);
         hold_cnt     <= '0;
         grant_valid  <= 1'b0;
         grant_idx    <= '0;
         grant_onehot <= '0;
         timeout_o    <= 1'b0;
      end else begin
         state        <= state_nxt;
         last_ptr     <= last_nxt;
         hold_cnt     <= hold_nxt;
         grant_valid  <= valid_nxt;
         grant_idx    <= idx_nxt;
         grant_onehot <= onehot_nxt;
         timeout_o    <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Purpose : self-checking bench for rr_decode_arbiter against a grant-level model.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : none; inputs driven right after sampling.
module tb_rr_decode_arbiter;

   localparam int MAXH = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       release_i;
   logic       grant_valid;
   logic [2:0] grant_idx;
   logic [7:0] grant_onehot;
   logic       timeout_o;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the resource (-1 = nobody), last owner,
   // cycles held so far, and the pending timeout flag.
   int m_owner;
   int m_last;
   int m_hold;
   bit m_to;

   rr_decode_arbiter #(
      .NREQ(8), .IDX_W(3), .MAX_HOLD(MAXH), .HOLD_W(4)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .release_i(release_i),
      .grant_valid(grant_valid), .grant_idx(grant_idx),
      .grant_onehot(grant_onehot), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   function automatic int pick(int last, logic [7:0] r);
      for (int k = 1; k <= 8; k++) begin
         if (r[(last + k) % 8]) return (last + k) % 8;
      end
      return -1;
   endfunction

   function automatic logic [12:0] exp_vec();
      logic [7:0] oh;
      logic [2:0] ix;
      oh = 8'h00;
      ix = 3'd0;
      if (m_owner >= 0) begin
         oh = 8'h01 << m_owner;
         ix = 3'(m_owner);
      end
      return {m_owner >= 0, ix, oh, m_to};
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = 7;
      m_hold  = 0;
      m_to    = 1'b0;
   endtask

   task automatic model_edge();
      bit a, b, c;
      int w;
      if (m_owner >= 0) begin
         a = !req[m_owner];
         b = release_i;
         c = (MAXH != 0) && (m_hold == MAXH);
         if (a || b || c) begin
            m_last  = m_owner;
            m_owner = -1;
            m_hold  = 0;
            m_to    = c && !a && !b;
         end else begin
            m_hold = (m_hold < 15) ? m_hold + 1 : 15;
            m_to   = 1'b0;
         end
      end else begin
         m_to = 1'b0;
         w = pick(m_last, req);
         if (w >= 0) begin
            m_owner = w;
            m_hold  = 1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 8'hFF; release_i = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({grant_valid, grant_idx, grant_onehot, timeout_o} !== 13'h0) begin
         errors++;
         $display("FAIL reset_async got=%h want=0", {grant_valid, grant_idx, grant_onehot, timeout_o});
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({grant_valid, grant_idx, grant_onehot, timeout_o} !== 13'h0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got=%h want=0", i, {grant_valid, grant_idx, grant_onehot, timeout_o});
         end
      end
      rst = 1'b0;
      step();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || grant_onehot !== 8'h01) begin
         errors++;
         $display("FAIL reset_first_grant got v=%b idx=%0d oh=%h want v=1 idx=0 oh=01", grant_valid, grant_idx, grant_onehot);
      end
   endtask

   task automatic test_rotation();
      logic [2:0] want;
      for (int n = 0; n < 9; n++) begin
         want = 3'(n % 8);
         if (n > 0) step();
         checks++;
         if (grant_valid !== 1'b1 || grant_idx !== want || {grant_valid, grant_idx, grant_onehot, timeout_o} !== exp_vec()) begin
            errors++;
            $display("FAIL rotation n=%0d got v=%b idx=%0d want v=1 idx=%0d", n, grant_valid, grant_idx, want);
         end
         release_i = 1'b1;
         step();
         release_i = 1'b0;
         checks++;
         if ({grant_valid, grant_idx, grant_onehot, timeout_o} !== 13'h0) begin
            errors++;
            $display("FAIL rotation_gap n=%0d got=%h want=0", n, {grant_valid, grant_idx, grant_onehot, timeout_o});
         end
      end
   endtask

   task automatic test_timeout();
      // Entered in the dead cycle; the req seen here decides the next owner.
      req = 8'h10;
      for (int i = 1; i <= MAXH; i++) begin
         step();
         checks++;
         if (grant_valid !== 1'b1 || grant_idx !== 3'd4 || grant_onehot !== 8'h10 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hold cyc=%0d got v=%b idx=%0d oh=%h to=%b want v=1 idx=4", i, grant_valid, grant_idx, grant_onehot, timeout_o);
         end
      end
      step();
      checks++;
      if (grant_valid !== 1'b0 || timeout_o !== 1'b1 || {grant_valid, grant_idx, grant_onehot, timeout_o} !== exp_vec()) begin
         errors++;
         $display("FAIL timeout_gap got v=%b to=%b want v=0 to=1", grant_valid, timeout_o);
      end
      step();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd4 || timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_regrant got v=%b idx=%0d to=%b want v=1 idx=4 to=0", grant_valid, grant_idx, timeout_o);
      end
   endtask

   task automatic test_wrap();
      logic [2:0] want [4] = '{3'd6, 3'd7, 3'd0, 3'd2};
      logic [7:0] reqs [4] = '{8'h40, 8'h81, 8'h81, 8'h04};
      for (int n = 0; n < 4; n++) begin
         req = reqs[n];
         // Grant 7 must be ended by release since req[7] stays set.
         release_i = (n == 2);
         step();
         release_i = 1'b0;
         checks++;
         if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_gap n=%0d got v=%b want v=0", n, grant_valid);
         end
         step();
         checks++;
         if (grant_valid !== 1'b1 || grant_idx !== want[n] || {grant_valid, grant_idx, grant_onehot, timeout_o} !== exp_vec()) begin
            errors++;
            $display("FAIL wrap n=%0d got v=%b idx=%0d want v=1 idx=%0d", n, grant_valid, grant_idx, want[n]);
         end
      end
   endtask

   task automatic test_simultaneous();
      // Owner 2 is in its first cycle; walk to the last allowed cycle.
      for (int i = 2; i <= MAXH; i++) step();
      release_i = 1'b1;
      step();
      release_i = 1'b0;
      checks++;
      if (grant_valid !== 1'b0 || timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL simul_release got v=%b to=%b want v=0 to=0", grant_valid, timeout_o);
      end
      step();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd2) begin
         errors++;
         $display("FAIL simul_regrant got v=%b idx=%0d want v=1 idx=2", grant_valid, grant_idx);
      end
      req = 8'h00;
      step();
      checks++;
      if (grant_valid !== 1'b0 || timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL simul_reqdrop got v=%b to=%b want v=0 to=0", grant_valid, timeout_o);
      end
      step();
      checks++;
      if ({grant_valid, grant_idx, grant_onehot, timeout_o} !== 13'h0 || exp_vec() !== 13'h0) begin
         errors++;
         $display("FAIL simul_idle got=%h want=0", {grant_valid, grant_idx, grant_onehot, timeout_o});
      end
   endtask

   task automatic test_async_reset();
      req = 8'h20;
      step();
      step();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd5) begin
         errors++;
         $display("FAIL async_setup got v=%b idx=%0d want v=1 idx=5", grant_valid, grant_idx);
      end
      #2 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({grant_valid, grant_idx, grant_onehot, timeout_o} !== 13'h0) begin
         errors++;
         $display("FAIL async_drop got=%h want=0", {grant_valid, grant_idx, grant_onehot, timeout_o});
      end
      #1 rst = 1'b0;
      req = 8'h21;
      step();
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || grant_onehot !== 8'h01) begin
         errors++;
         $display("FAIL async_after got v=%b idx=%0d oh=%h want v=1 idx=0 oh=01", grant_valid, grant_idx, grant_onehot);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 3))
               0:       req = 8'h00;
               1:       req = 8'($urandom());
               2:       req = 8'h01 << $urandom_range(0, 7);
               default: req = 8'($urandom()) & 8'($urandom());
            endcase
         end
         release_i = ($urandom_range(0, 24) == 0);
         rst       = ($urandom_range(0, 149) == 0);
         if (rst) begin
            model_reset();
            #1;
            checks++;
            if ({grant_valid, grant_idx, grant_onehot, timeout_o} !== 13'h0) begin
               errors++;
               $display("FAIL rand_async i=%0d got=%h want=0", i, {grant_valid, grant_idx, grant_onehot, timeout_o});
            end
         end
         step();
         checks++;
         if ({grant_valid, grant_idx, grant_onehot, timeout_o} !== exp_vec()) begin
            errors++;
            $display("FAIL rand i=%0d got=%h want=%h req=%h", i, {grant_valid, grant_idx, grant_onehot, timeout_o}, exp_vec(), req);
         end
         checks++;
         if ($countones(grant_onehot) != int'(grant_valid) || (grant_valid && grant_onehot !== (8'h01 << grant_idx))) begin
            errors++;
            $display("FAIL rand_onehot i=%0d got oh=%h v=%b idx=%0d", i, grant_onehot, grant_valid, grant_idx);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_timeout();
      test_wrap();
      test_simultaneous();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
